// File: rtl/sbus_ahbl_master_if.sv
// Bundles the SBUS request/response port and the AHB-Lite manager port of
// the SBUS-to-AHB-Lite bridge.
`timescale 1ns/1ps
interface sbus_ahbl_master_if;
   logic [31:0] sbus_addr;
   logic        sbus_write;
   logic [1:0]  sbus_size;
   logic        sbus_vld;
   logic [31:0] sbus_wdata;
   logic        sbus_rdy;
   logic        sbus_err;
   logic [31:0] sbus_rdata;

   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [7:0]  hmaster;
   logic        hmastlock;
   logic [31:0] hwdata;
   logic        hready;
   logic        hresp;
   logic [31:0] hrdata;

   modport master (
      input  sbus_addr, sbus_write, sbus_size, sbus_vld, sbus_wdata,
      output sbus_rdy, sbus_err, sbus_rdata,
      output haddr, hwrite, htrans, hsize, hburst, hprot, hmaster, hmastlock, hwdata,
      input  hready, hresp, hrdata
   );

   modport slave (
      output sbus_addr, sbus_write, sbus_size, sbus_vld, sbus_wdata,
      input  sbus_rdy, sbus_err, sbus_rdata,
      input  haddr, hwrite, htrans, hsize, hburst, hprot, hmaster, hmastlock, hwdata,
      output hready, hresp, hrdata
   );
endinterface

// File: rtl/sbus_ahbl_master.sv
// SBUS initiator to AHB-Lite manager bridge: one single-beat transfer per
// request, narrow-lane placement/extraction, AHB ERROR mapped to sbus_err.
`timescale 1ns/1ps
module sbus_ahbl_master #(
   parameter logic [7:0] HMASTER_ID = 8'h00,
   parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
   input logic              clk,
   input logic              rst_n,
   sbus_ahbl_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t      state, state_n;
   logic [31:0] haddr_q, haddr_n;
   logic        hwrite_q, hwrite_n;
   logic [1:0]  htrans_q, htrans_n;
   logic [2:0]  hsize_q, hsize_n;
   logic [31:0] hwdata_q, hwdata_n;
   logic        rdy_q, rdy_n;
   logic        err_q, err_n;
   logic [31:0] rdata_q, rdata_n;
   logic [1:0]  lane_q, lane_n;
   logic [1:0]  size_q, size_n;
   logic        misaligned;
   logic [31:0] wdata_rep;

   always_comb begin
      misaligned = 1'b0;
      wdata_rep  = bus.sbus_wdata;
      unique case (bus.sbus_size)
         2'd0: wdata_rep = {4{bus.sbus_wdata[7:0]}};
         2'd1: begin
            misaligned = bus.sbus_addr[0];
            wdata_rep  = {2{bus.sbus_wdata[15:0]}};
         end
         2'd2: misaligned = |bus.sbus_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   always_comb begin
      state_n  = state;
      haddr_n  = haddr_q;
      hwrite_n = hwrite_q;
      htrans_n = htrans_q;
      hsize_n  = hsize_q;
      hwdata_n = hwdata_q;
      rdata_n  = rdata_q;
      lane_n   = lane_q;
      size_n   = size_q;
      rdy_n    = 1'b0;
      err_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.sbus_vld) begin
               if (misaligned) begin
                  state_n = RESP;
                  rdy_n   = 1'b1;
                  err_n   = 1'b1;
               end else begin
                  state_n  = ADDR;
                  haddr_n  = bus.sbus_addr;
                  hwrite_n = bus.sbus_write;
                  hsize_n  = {1'b0, bus.sbus_size};
                  htrans_n = 2'b10;
                  hwdata_n = wdata_rep;
                  lane_n   = bus.sbus_addr[1:0];
                  size_n   = bus.sbus_size;
               end
            end
         end
         ADDR: begin
            if (bus.hready) begin
               state_n  = DATA;
               htrans_n = 2'b00;
            end
         end
         DATA: begin
            // hresp with hready low is the first ERROR cycle; only hready ends the wait
            if (bus.hready) begin
               state_n = RESP;
               rdy_n   = 1'b1;
               err_n   = bus.hresp;
               if (!hwrite_q && !bus.hresp) begin
                  unique case (size_q)
                     2'd0:    rdata_n = {24'h0, bus.hrdata[{lane_q, 3'b000} +: 8]};
                     2'd1:    rdata_n = {16'h0, bus.hrdata[{lane_q[1], 4'b0000} +: 16]};
                     default: rdata_n = bus.hrdata;
                  endcase
               end
            end
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         htrans_q <= '0;
         hsize_q  <= '0;
         hwdata_q <= '0;
         rdy_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         lane_q   <= '0;
         size_q   <= '0;
      end else begin
         state    <= state_n;
         haddr_q  <= haddr_n;
         hwrite_q <= hwrite_n;
         htrans_q <= htrans_n;
         hsize_q  <= hsize_n;
         hwdata_q <= hwdata_n;
         rdy_q    <= rdy_n;
         err_q    <= err_n;
         rdata_q  <= rdata_n;
         lane_q   <= lane_n;
         size_q   <= size_n;
      end
   end

   assign bus.haddr      = haddr_q;
   assign bus.hwrite     = hwrite_q;
   assign bus.htrans     = htrans_q;
   assign bus.hsize      = hsize_q;
   assign bus.hwdata     = hwdata_q;
   assign bus.hburst     = 3'b000;
   assign bus.hprot      = HPROT_VAL;
   assign bus.hmaster    = HMASTER_ID;
   assign bus.hmastlock  = 1'b0;
   assign bus.sbus_rdy   = rdy_q;
   assign bus.sbus_err   = err_q;
   assign bus.sbus_rdata = rdata_q;
endmodule

// File: tb/tb_sbus_ahbl_master.sv
// Directed plus randomized bench for sbus_ahbl_master; the expected cycle
// schedule and lane arithmetic come from a transaction-level model.
`timescale 1ns/1ps
module tb_sbus_ahbl_master;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;
   int unsigned req_cyc = 0;
   int unsigned nonseq_cyc = 0;
   logic [31:0] exp_rdata = '0;

   sbus_ahbl_master_if bus ();

   sbus_ahbl_master #(.HMASTER_ID(8'h5A), .HPROT_VAL(4'b0011)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_htrans"}, bus.htrans, 0);
      chk({tag, "_haddr"}, bus.haddr, 0);
      chk({tag, "_hwrite"}, bus.hwrite, 0);
      chk({tag, "_hsize"}, bus.hsize, 0);
      chk({tag, "_hwdata"}, bus.hwdata, 0);
      chk({tag, "_rdy"}, bus.sbus_rdy, 0);
      chk({tag, "_err"}, bus.sbus_err, 0);
      chk({tag, "_rdata"}, bus.sbus_rdata, 0);
   endtask

   // One request issued in cycle 0; aw/dw are address/data wait states,
   // er requests a two-cycle ERROR (needs dw >= 1), rd is the bus read word.
   task automatic do_req(input logic [31:0] a, input logic w, input logic [1:0] sz,
                         input logic [31:0] wd, input int unsigned aw, input int unsigned dw,
                         input logic er, input logic [31:0] rd);
      logic mis;
      int unsigned last;
      logic [31:0] rep;
      @(negedge clk);
      chk("idle_rdy", bus.sbus_rdy, 0);
      chk("idle_htrans", bus.htrans, 0);
      bus.sbus_vld   = 1'b1;
      bus.sbus_addr  = a;
      bus.sbus_write = w;
      bus.sbus_size  = sz;
      bus.sbus_wdata = wd;
      bus.hready     = 1'b1;
      bus.hresp      = 1'b0;
      req_cyc = cyc;
      mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      last = mis ? 1 : 3 + aw + dw;
      if (sz == 2'd0)      rep = {24'h0, wd[7:0]} * 32'h0101_0101;
      else if (sz == 2'd1) rep = {16'h0, wd[15:0]} * 32'h0001_0001;
      else                 rep = wd;
      if (!mis && !w && !er) begin
         if (sz == 2'd0)      exp_rdata = (rd >> (8 * a[1:0])) & 32'hFF;
         else if (sz == 2'd1) exp_rdata = (rd >> (16 * a[1])) & 32'hFFFF;
         else                 exp_rdata = rd;
      end
      for (int unsigned c = 1; c <= last; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.sbus_addr  = $urandom;
            bus.sbus_wdata = $urandom;
            bus.sbus_size  = 2'($urandom_range(0, 3));
            bus.sbus_write = 1'($urandom_range(0, 1));
         end
         if (c == last) begin
            chk("resp_rdy", bus.sbus_rdy, 1);
            chk("resp_err", bus.sbus_err, {31'h0, mis | er});
            chk("resp_rdata", bus.sbus_rdata, exp_rdata);
            chk("resp_htrans", bus.htrans, 0);
            bus.sbus_vld = 1'b0;
            bus.hready   = 1'b1;
            bus.hresp    = 1'b0;
         end else begin
            chk("busy_rdy", bus.sbus_rdy, 0);
            chk("hwdata", bus.hwdata, rep);
            if (c <= 1 + aw) begin
               if (c == 1) nonseq_cyc = cyc;
               chk("addr_htrans", bus.htrans, 2);
               chk("addr_haddr", bus.haddr, a);
               chk("addr_hsize", bus.hsize, {30'h0, sz});
               chk("addr_hwrite", bus.hwrite, {31'h0, w});
               bus.hready = (c == 1 + aw);
               bus.hresp  = 1'b0;
            end else begin
               chk("data_htrans", bus.htrans, 0);
               bus.hready = (c == last - 1);
               bus.hresp  = er && (c + 2 >= last);
               bus.hrdata = (c == last - 1) ? rd : $urandom;
            end
         end
      end
   endtask

   initial begin
      int unsigned first_req;
      bus.sbus_vld = 1'b0; bus.sbus_addr = '0; bus.sbus_write = 1'b0;
      bus.sbus_size = '0; bus.sbus_wdata = '0;
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
      #1;
      chk_reset_outputs("reset");
      #20;
      rst_n = 1'b1;
      chk("hburst", bus.hburst, 0);
      chk("hprot", bus.hprot, 4'b0011);
      chk("hmaster", bus.hmaster, 8'h5A);
      chk("hmastlock", bus.hmastlock, 0);

      do_req(32'h2000_0010, 1'b1, 2'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0);
      do_req(32'h4000_0003, 1'b0, 2'd0, 32'h0, 0, 0, 1'b0, 32'hAABB_CCDD);
      do_req(32'h4000_0002, 1'b0, 2'd1, 32'h0, 0, 0, 1'b0, 32'hAABB_CCDD);
      do_req(32'h4000_0004, 1'b1, 2'd1, 32'h1234_5678, 0, 0, 1'b0, 32'h0);
      do_req(32'h4000_0001, 1'b1, 2'd0, 32'h1234_5678, 0, 0, 1'b0, 32'h0);
      do_req(32'h5000_0008, 1'b0, 2'd2, 32'h0, 2, 3, 1'b0, 32'h0BAD_F00D);
      do_req(32'h5000_000C, 1'b0, 2'd2, 32'h0, 0, 1, 1'b1, 32'h1111_2222);
      do_req(32'h6000_0002, 1'b1, 2'd2, 32'h5555_5555, 0, 0, 1'b0, 32'h0);
      do_req(32'h6000_0000, 1'b0, 2'd3, 32'h0, 0, 0, 1'b0, 32'h0);

      do_req(32'h7000_0000, 1'b0, 2'd2, 32'h0, 0, 0, 1'b0, 32'hCAFE_0001);
      first_req = req_cyc;
      do_req(32'h7000_0004, 1'b1, 2'd2, 32'h0000_0042, 0, 0, 1'b0, 32'h0);
      chk("b2b_nonseq_cycle", nonseq_cyc - first_req, 5);

      for (int i = 0; i < 40; i++) begin
         logic [1:0] sz;
         int unsigned aw, dw;
         logic er;
         sz = 2'($urandom_range(0, 3));
         aw = $urandom_range(0, 3);
         dw = $urandom_range(0, 3);
         er = (dw >= 1) && ($urandom_range(0, 3) == 0);
         do_req($urandom, 1'($urandom_range(0, 1)), sz, $urandom, aw, dw, er, $urandom);
      end

      @(negedge clk);
      bus.sbus_vld = 1'b1; bus.sbus_addr = 32'h8000_0000; bus.sbus_write = 1'b0;
      bus.sbus_size = 2'd2; bus.hready = 1'b1; bus.hresp = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.hready = 1'b0;
      chk("rst_pre_data_htrans", bus.htrans, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      bus.sbus_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.hready = 1'b1;
      exp_rdata = '0;
      do_req(32'h9000_0002, 1'b0, 2'd1, 32'h0, 1, 0, 1'b0, 32'hFEDC_BA98);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
